// File: rtl/fpu_add_sched_pkg.sv
// Shared FPU definitions: scheduler FSM states, IEEE-754 field widths and word layouts.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned SP_EXP_W = 8;
    localparam int unsigned SP_MAN_W = 23;
    localparam int unsigned DP_EXP_W = 11;
    localparam int unsigned DP_MAN_W = 52;

    typedef struct packed {
        logic                sign;
        logic [SP_EXP_W-1:0] exponent;
        logic [SP_MAN_W-1:0] mantissa;
    } sp_word_t;

    typedef struct packed {
        logic                sign;
        logic [DP_EXP_W-1:0] exponent;
        logic [DP_MAN_W-1:0] mantissa;
    } dp_word_t;

    function automatic int unsigned fp_exp_w(input bit dbl);
        return dbl ? DP_EXP_W : SP_EXP_W;
    endfunction

    function automatic int unsigned fp_man_w(input bit dbl);
        return dbl ? DP_MAN_W : SP_MAN_W;
    endfunction

    function automatic int unsigned fp_width(input bit dbl);
        return SIGN_W + fp_exp_w(dbl) + fp_man_w(dbl);
    endfunction

endpackage

// File: rtl/fpu_add_sched_if.sv
// Request/response bundle between the DSP clients and the shared adder scheduler.
interface fpu_add_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [W-1:0]         resp_result;
    logic                 resp_exception;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_exception
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_exception
    );
endinterface

// File: rtl/fpu_add_sched_fpu_add.sv
// Combinational IEEE-754 adder, round-to-nearest-even, subnormals supported.
// exception flags an invalid operation (NaN result) or overflow of finite operands.
module fpu_add
    import fpu_pkg::*;
#(
    parameter bit double = 1'b0
) (
    input  logic [fp_width(double)-1:0] a,
    input  logic [fp_width(double)-1:0] b,
    output logic [fp_width(double)-1:0] result,
    output logic                        exception
);
    localparam int unsigned W  = fp_width(double);
    localparam int unsigned E  = fp_exp_w(double);
    localparam int unsigned M  = fp_man_w(double);
    localparam int unsigned XW = M + 4;
    localparam logic [E-1:0] EMAX = '1;

    logic [W-1:0]  x, y;
    logic [E-1:0]  e_x, e_y, ex_eff, ey_eff, d;
    logic          eff_sub, nan_in, inf_x, inf_y, sticky, r_inc, res_sign;
    logic [XW-1:0] big, sml, norm;
    logic [XW:0]   sum;
    logic [E:0]    e_res, e_fin;
    logic [M+1:0]  rnd;
    logic [M-1:0]  man;

    always_comb begin
        // Order operands by magnitude so alignment only ever shifts y
        x = a;
        y = b;
        if (b[W-2:0] > a[W-2:0]) begin
            x = b;
            y = a;
        end
        e_x     = x[W-2 -: E];
        e_y     = y[W-2 -: E];
        eff_sub = x[W-1] ^ y[W-1];
        inf_x   = (e_x == EMAX) && (x[M-1:0] == '0);
        inf_y   = (e_y == EMAX) && (y[M-1:0] == '0);
        nan_in  = ((e_x == EMAX) && (x[M-1:0] != '0)) || ((e_y == EMAX) && (y[M-1:0] != '0));
        ex_eff  = (e_x == '0) ? E'(1) : e_x;
        ey_eff  = (e_y == '0) ? E'(1) : e_y;
        d       = ex_eff - ey_eff;

        big    = {(e_x != '0), x[M-1:0], 3'b000};
        sml    = {(e_y != '0), y[M-1:0], 3'b000};
        sticky = 1'b0;
        for (int i = 0; i < int'(XW); i++) begin
            if (E'(i) < d) begin
                sticky = sticky | sml[0];
                sml    = sml >> 1;
            end
        end
        sml[0] = sml[0] | sticky;

        sum   = eff_sub ? ({1'b0, big} - {1'b0, sml}) : ({1'b0, big} + {1'b0, sml});
        e_res = {1'b0, ex_eff};
        if (sum[XW]) begin
            norm    = sum[XW:1];
            norm[0] = norm[0] | sum[0];
            e_res   = e_res + (E+1)'(1);
        end else begin
            norm = sum[XW-1:0];
        end
        // Cancellation: renormalise, but never below the subnormal exponent
        for (int i = 0; i < int'(XW); i++) begin
            if (!norm[XW-1] && (e_res > (E+1)'(1))) begin
                norm  = norm << 1;
                e_res = e_res - (E+1)'(1);
            end
        end

        r_inc = norm[2] && (norm[1] || norm[0] || norm[3]);
        rnd   = {1'b0, norm[XW-1:3]} + (M+2)'(r_inc);
        if (rnd[M+1]) begin
            man   = rnd[M:1];
            e_fin = e_res + (E+1)'(1);
        end else begin
            man   = rnd[M-1:0];
            e_fin = rnd[M] ? e_res : '0;
        end

        res_sign  = (eff_sub && (norm == '0)) ? 1'b0 : x[W-1];
        result    = {res_sign, e_fin[E-1:0], man};
        exception = 1'b0;
        if (e_fin >= {1'b0, EMAX}) begin
            result    = {res_sign, EMAX, M'(0)};
            exception = 1'b1;
        end
        if (nan_in || (inf_x && inf_y && eff_sub)) begin
            result    = {1'b0, EMAX, 1'b1, (M-1)'(0)};
            exception = 1'b1;
        end else if (inf_x) begin
            result    = {x[W-1], EMAX, M'(0)};
            exception = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_add_sched_rr_arbiter.sv
// Round-robin grant: search begins one past the previous winner and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_idx_c
);
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(last) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one fpu_add between NUM_REQ requesters.
// Operands and result are registered; a request handshake yields resp_valid two cycles later.
module fpu_add_sched
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter bit          DOUBLE  = 1'b0,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    fpu_add_sched_if.slave bus,
    output logic           busy,
    output logic [15:0]    ops_done
);
    localparam int unsigned W = fp_width(DOUBLE);

    sched_state_e       state_q, state_d;
    logic               arb_en_c, capture_c, resp_hs_c, load_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    grant_idx_c, last_q, op_id_q;
    logic [W-1:0]       op_a_q, op_b_q, sel_a_c, sel_b_c, sum_c;
    logic               exc_c;

    // Grants are suppressed during reset so no handshake completes in a reset cycle
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (bus.req_valid),
        .last        (last_q),
        .en          (arb_en_c & rst_n),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign bus.req_ready = grant_c;
    assign load_c        = |grant_c;

    fpu_add #(
        .double (DOUBLE)
    ) u_add (
        .a         (op_a_q),
        .b         (op_b_q),
        .result    (sum_c),
        .exception (exc_c)
    );

    // One-hot operand mux driven by the grant vector
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i]) begin
                sel_a_c = sel_a_c | bus.req_a[i*W +: W];
                sel_b_c = sel_b_c | bus.req_b[i*W +: W];
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        arb_en_c  = 1'b0;
        capture_c = 1'b0;
        resp_hs_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                arb_en_c = 1'b1;
                if (|bus.req_valid) state_d = EXEC;
            end
            EXEC: begin
                capture_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_hs_c = 1'b1;
                    arb_en_c  = 1'b1;
                    state_d   = (|bus.req_valid) ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            last_q             <= ID_W'(NUM_REQ - 1);
            op_id_q            <= '0;
            op_a_q             <= '0;
            op_b_q             <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_id        <= '0;
            bus.resp_result    <= '0;
            bus.resp_exception <= 1'b0;
            busy               <= 1'b0;
            ops_done           <= '0;
        end else begin
            state_q        <= state_d;
            busy           <= (state_d != IDLE);
            bus.resp_valid <= (state_d == RESP);
            if (load_c) begin
                op_a_q  <= sel_a_c;
                op_b_q  <= sel_b_c;
                op_id_q <= grant_idx_c;
                last_q  <= grant_idx_c;
            end
            if (capture_c) begin
                bus.resp_result    <= sum_c;
                bus.resp_exception <= exc_c;
                bus.resp_id        <= op_id_q;
            end
            if (resp_hs_c) ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Shared-access scheduler for one `fpu_add` instance. It accepts add requests from `NUM_REQ` independent requesters over valid/ready handshakes and grants them round-robin. It registers the granted operands, drives the single combinational adder, and returns each result on one tagged response channel. It sits between the DSP datapath clients and the FPU so the adder area is paid once.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DOUBLE`, 0: passed to `fpu_add` as `double`. Word width `W` = 32 when 0, 64 when 1.
- `ID_W`, `$clog2(NUM_REQ)`: width of the response tag.

- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*W  operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NUM_REQ*W  operand B, same packing as `req_a`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  ID_W  index of the requester that owns the result.
- `resp_result`  out  W  sum from `fpu_add`.
- `resp_exception`  out  1  `fpu_add` exception flag, registered with the result.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  16  count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- FSM states:
  - IDLE: no operation held.
  - EXEC: operands are latched and the adder is evaluating.
  - RESP: the result is registered and `resp_valid` is high.
- IDLE:
  - If any `req_valid` is high, the arbiter raises `req_ready` for exactly one requester, the winner.
  - On that handshake, latch the winner's `req_a`, `req_b` and id, then go to EXEC.
  - If no `req_valid` is high, stay in IDLE.
- EXEC:
  - `fpu_add` sees the latched operands.
  - At the clock edge, the result and exception are captured into the response registers, then go to RESP.
  - `req_ready` is all zero.
- RESP:
  - `resp_valid` is 1. `resp_id`, `resp_result` and `resp_exception` are stable until the handshake.
  - With `resp_ready`=0: stay in RESP. `req_ready` is all zero.
  - With `resp_ready`=1 and no `req_valid`: go to IDLE.
  - With `resp_ready`=1 and any `req_valid`: grant in the same cycle (`req_ready` is combinational on `resp_ready`), latch the new operands, go to EXEC. This is back-to-back issue.
- Round-robin arbitration:
  - The pointer `last` holds the most recent winner.
  - The search starts at `last`+1 and wraps modulo `NUM_REQ`.
  - `last` updates only on a request handshake, never when a request is merely pending.
  - Reset value of `last` is `NUM_REQ`-1, so requester 0 wins first.
- `req_ready` depends only on state, `last`, `req_valid` and `resp_ready`; it never depends on operand values.
- A requester that drops `req_valid` before being granted is simply skipped. There is no penalty.
- `ops_done` increments on each `resp_valid && resp_ready` cycle.

## Timing
- Latency: request handshake in cycle N gives `resp_valid` in cycle N+2.
- Throughput: one operation every 2 cycles with `resp_ready` held high. One every 3 cycles if the FSM passes through IDLE.
- Only the adder's combinational path is inside EXEC; operands and result are both registered.
- Values during reset (`rst_n`=0 at an edge):
  - State IDLE, `last`=`NUM_REQ`-1.
  - `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_exception`=0.
  - `busy`=0, `ops_done`=0, `req_ready`=0.
- Reset mid-operation discards any in-flight or held result without a response. No handshake completes in a reset cycle.

## Structure
- Package `fpu_pkg`:
  - FSM state enum: IDLE, EXEC, RESP.
  - Width function giving W from `DOUBLE`.
  - Field constants for sign, exponent and mantissa, shared with the other FPU blocks.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - Inputs: request vector, `last` pointer, enable.
  - Outputs: one-hot grant and its binary index.
- Top level contains the FSM, the operand, id and result registers, the `fpu_add` instance and the `ops_done` counter.

## Test plan
- Single add: requester 0 sends a=0x3F800000, b=0x3F800000. Response is 2 cycles after the handshake with result 0x40000000, id 0, `ops_done`=1.
- Sign cases: 2.0+3.0 (0x40000000, 0x40400000) gives 0x40A00000. -1.0+1.0 (0xBF800000, 0x3F800000) gives 0x00000000. Inf+1.0 (0x7F800000, 0x3F800000) gives 0x7F800000.
- Fairness: requesters 0, 1 and 3 hold valid continuously with `resp_ready`=1. Grant order is 0,1,3,0,1,3, and each response id matches its request.
- Back-to-back: two requesters valid, `resp_ready`=1. Handshakes occur every 2 cycles, and `req_ready` rises in the RESP cycle.
- Backpressure: `resp_ready`=0 for 5 cycles in RESP. `resp_*` stay constant, `req_ready`=0, `ops_done` unchanged. Release gives exactly one handshake.
- Reset mid-op: assert `rst_n`=0 in EXEC. Next cycle all outputs are at reset values and no response for that request ever appears. After release, requester 0 wins first.
